// File: rtl/gate_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gate_input_debounce
// Description : Two-channel switch conditioner. Each channel synchronises a
//               raw asynchronous switch, rejects bounce with a tick-based
//               stability counter and emits registered one-cycle RISE/FALL
//               pulses on every accepted transition.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_input_debounce #(
  parameter int DIV        = 50000, // sample-tick prescaler in CLK cycles (>=2)
  parameter int STABLE_CNT = 8      // ticks a new level must persist (>=1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW_A,
  input  logic SW_B,
  output logic A,
  output logic B,
  output logic A_RISE,
  output logic A_FALL,
  output logic B_RISE,
  output logic B_FALL,
  output logic TICK
);

  localparam int c_PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_CNT_W = ($clog2(STABLE_CNT + 1) > 0) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_MAX  = c_PRE_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CNT - 1);

  // --------------------------------------------------------------------------
  // Shared sample-tick prescaler
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0] pre_q, pre_d;
  logic               tick_q, tick_d;

  // Next prescaler count; the strobe is pre-computed so TICK is registered
  // yet high exactly while the counter sits at its terminal value.
  always_comb begin
    pre_d  = (pre_q == c_PRE_MAX) ? '0 : pre_q + 1'b1;
    tick_d = (pre_d == c_PRE_MAX);
  end

  // Prescaler and strobe registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel synchroniser + stability filter (channel 0 = A, 1 = B)
  // --------------------------------------------------------------------------
  logic [1:0] sw_w;
  logic [1:0] lvl_w;
  logic [1:0] rise_w;
  logic [1:0] fall_w;

  assign sw_w = {SW_B, SW_A};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      logic               s1_q, s2_q;
      logic               lvl_q, lvl_d;
      logic               rise_q, rise_d;
      logic               fall_q, fall_d;
      logic [c_CNT_W-1:0] cnt_q, cnt_d;

      // Filter decision: any return to the accepted level restarts
      // qualification; otherwise advance only on sample ticks and accept
      // the new level on the last required tick.
      always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == lvl_q) begin
          cnt_d = '0;
        end else if (tick_q) begin
          if (cnt_q == c_CNT_LAST) begin
            lvl_d  = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Two-flop synchroniser and filter state; pulses register alongside
      // the level so they coincide with its first cycle at the new value.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          lvl_q  <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          s1_q   <= sw_w[g];
          s2_q   <= s1_q;
          lvl_q  <= lvl_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
          cnt_q  <= cnt_d;
        end
      end

      assign lvl_w[g]  = lvl_q;
      assign rise_w[g] = rise_q;
      assign fall_w[g] = fall_q;
    end
  endgenerate

  assign A      = lvl_w[0];
  assign B      = lvl_w[1];
  assign A_RISE = rise_w[0];
  assign A_FALL = fall_w[0];
  assign B_RISE = rise_w[1];
  assign B_FALL = fall_w[1];
  assign TICK   = tick_q;

endmodule
`default_nettype wire

// File: doc/gate_input_debounce.md
Name: gate_input_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the basic-gate logic.
- Takes the two raw, asynchronous, bouncing switch inputs and drives the clean A and B operands into the gate block.
- Per channel it synchronises the input, filters bounce with a tick-based stability counter, and flags accepted transitions with single-cycle edge pulses for lab counters and LEDs.
- Both channels are identical and fully independent.

Parameters:
DIV, 50000, sample-tick prescaler in CLK cycles (≥2); one tick every DIV cycles
STABLE_CNT, 8, consecutive ticks a new level must persist before it is accepted (≥1)

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK
SW_A  input  1  raw switch A, asynchronous, may bounce
SW_B  input  1  raw switch B, asynchronous, may bounce
A  output  1  debounced level of SW_A; feeds the gate stage
B  output  1  debounced level of SW_B; feeds the gate stage
A_RISE  output  1  one-cycle pulse when A goes 0->1
A_FALL  output  1  one-cycle pulse when A goes 1->0
B_RISE  output  1  one-cycle pulse when B goes 0->1
B_FALL  output  1  one-cycle pulse when B goes 1->0
TICK  output  1  one-cycle sample strobe (for observation/test)

Behaviour:
- Reset:
  - When RST_N=0 at a CLK edge, all of the following clear to 0 on that edge: synchroniser flops, prescaler, per-channel counters, A, B, all edge pulses and TICK.
  - Reset mid-debounce discards any partial count; no pulse is emitted for the discarded transition.
  - After reset release, A/B start at 0. If a switch is already high, it is accepted through the normal debounce path and produces a RISE pulse.
- Synchroniser:
  - Two-flop chain per channel: SW_x -> s1_x -> s2_x.
  - No logic other than the chain itself touches SW_x before s2_x.
- Prescaler:
  - Counter runs 0..DIV-1 and wraps.
  - TICK=1 exactly in the cycle where the counter equals DIV-1, otherwise 0.
  - The first TICK occurs DIV cycles after reset release.
  - Counter width is ceil(log2(DIV)).
- Per-channel filter (counter width ceil(log2(STABLE_CNT+1))). Each cycle:
  - If s2_x == x: cnt_x <= 0. Any bounce back to the accepted level restarts qualification.
  - Else if TICK=0: hold.
  - Else if cnt_x == STABLE_CNT-1: x <= s2_x, cnt_x <= 0, assert the matching RISE/FALL pulse.
  - Else: cnt_x <= cnt_x+1.
- Edge pulses:
  - Registered; high in exactly the one cycle in which x first shows its new value, otherwise 0.
  - RISE and FALL of a channel are never high together.
  - Pulses are never asserted twice for one transition.
- Latency:
  - After s2_x first differs and stays stable, x changes between (STABLE_CNT-1)*DIV+1 and STABLE_CNT*DIV cycles later.
  - Add 2 cycles for the synchroniser from SW_x.
- Glitches: a disagreement shorter than (STABLE_CNT-1)*DIV+1 cycles never changes x.
- Simultaneous events:
  - A and B may change in the same cycle; all four pulses are independent.
  - A level change arriving in the same cycle as TICK counts that tick.
- Counter saturation cannot occur: cnt_x is reset on acceptance and never exceeds STABLE_CNT-1.
- All outputs are registered; there is no combinational path from SW_x to any output.

Test Plan (DIV=4, STABLE_CNT=3 unless stated):
- Reset behaviour: hold RST_N=0 for 5 cycles with SW_A=SW_B=1 -> A=B=0, all pulses 0, TICK 0 throughout. Release -> A=1 with exactly one A_RISE pulse; same for B; latency within 2+[9..12] cycles of release-plus-first-sync.
- Clean press: SW_A 0->1, held -> A rises 11 to 14 cycles after the SW_A change; A_RISE high exactly 1 cycle, coincident with A's first high cycle; A_FALL stays 0. Release -> symmetric A_FALL.
- Bounce rejection: SW_A toggles every 3 cycles for 40 cycles and then returns to 0 -> A stays 0; no pulses on A_RISE or A_FALL.
- Bounce then settle: SW_B toggles 5 times at 2-cycle spacing, then holds 1 -> exactly one B_RISE; B=1 no earlier than 9 cycles after the final toggle reaches s2.
- Independence/simultaneity: SW_A and SW_B rise in the same cycle -> A_RISE and B_RISE pulse in the same cycle. Then SW_A falls while SW_B bounces -> A_FALL only; B stays 1.
- Reset mid-operation: SW_A rises; assert RST_N=0 after 2 ticks for 1 cycle; keep SW_A=1 -> A=0 immediately after reset; A rises only after a full fresh qualification (≥9 cycles after the post-reset sync); one A_RISE total.
